// File: rtl/prim_ram_np_cfg_seq.sv
// prim_ram_np_cfg_seq: applies a captured per-port RAM configuration one port
// at a time, holding each port's requester around its update.
// Optional busy-wait timeout in HOLD: define PRIM_RAM_CFG_SEQ_TIMEOUT_EN.
//
//   state  | meaning
//   IDLE   | waiting for cfg_req_i
//   SEL    | compare shadow vs applied slice for port idx, skip if equal
//   HOLD   | port idx held, waiting for it to go idle
//   APPLY  | port idx held, its ram_cfg slice loads at the end of the cycle
//   SETTLE | port idx held while the new config settles
//   DONE   | one-cycle ack, then back to IDLE
module prim_ram_np_cfg_seq #(
  parameter int NumPorts      = 2,
  parameter int CfgW          = 4,
  parameter int SettleCycles  = 4,
  parameter int TimeoutCycles = 256,
  parameter logic [NumPorts*(CfgW+1)-1:0] ResetCfg = '0
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          cfg_req_i,
  input  logic [NumPorts*(CfgW+1)-1:0]  cfg_i,
  input  logic [NumPorts-1:0]           port_active_i,
  output logic [NumPorts-1:0]           port_hold_o,
  output logic [NumPorts*(CfgW+1)-1:0]  ram_cfg_o,
  output logic                          cfg_busy_o,
  output logic                          cfg_ack_o,
  output logic [NumPorts-1:0]           timeout_o
);

  localparam int SliceW = CfgW + 1;
  localparam int TotW   = NumPorts * SliceW;
  localparam int IdxW   = (NumPorts > 1) ? $clog2(NumPorts) : 1;
  localparam int SetW   = $clog2(SettleCycles + 1);

  if (NumPorts < 1) begin : g_bad_num_ports
    $error("prim_ram_np_cfg_seq: NumPorts must be >= 1");
  end
  if (SettleCycles < 1) begin : g_bad_settle
    $error("prim_ram_np_cfg_seq: SettleCycles must be >= 1");
  end
  if (TimeoutCycles < 1) begin : g_bad_timeout
    $error("prim_ram_np_cfg_seq: TimeoutCycles must be >= 1");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEL,
    ST_HOLD,
    ST_APPLY,
    ST_SETTLE,
    ST_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [TotW-1:0]   shadow_q, shadow_d;
  logic [TotW-1:0]   ram_cfg_q, ram_cfg_d;
  logic [SetW-1:0]   settle_q, settle_d;

  logic [SliceW-1:0] shadow_slice;
  logic [SliceW-1:0] cur_slice;
  logic              last_port;
  logic              active_sel;

`ifdef PRIM_RAM_CFG_SEQ_TIMEOUT_EN
  localparam int TmoW = $clog2(TimeoutCycles + 1);
  logic [TmoW-1:0]     tmo_cnt_q, tmo_cnt_d;
  logic [NumPorts-1:0] timeout_q, timeout_d;
`endif

  assign shadow_slice = shadow_q[int'(idx_q)*SliceW +: SliceW];
  assign cur_slice    = ram_cfg_q[int'(idx_q)*SliceW +: SliceW];
  assign last_port    = (int'(idx_q) == NumPorts - 1);
  assign active_sel   = port_active_i[idx_q];

  // Next-state and datapath updates for the port-by-port sequence.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    shadow_d  = shadow_q;
    ram_cfg_d = ram_cfg_q;
    settle_d  = settle_q;
`ifdef PRIM_RAM_CFG_SEQ_TIMEOUT_EN
    tmo_cnt_d = tmo_cnt_q;
    timeout_d = timeout_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (cfg_req_i) begin
          shadow_d = cfg_i;
          idx_d    = '0;
          state_d  = ST_SEL;
`ifdef PRIM_RAM_CFG_SEQ_TIMEOUT_EN
          timeout_d = '0;
`endif
        end
      end
      ST_SEL: begin
`ifdef PRIM_RAM_CFG_SEQ_TIMEOUT_EN
        tmo_cnt_d = TmoW'(TimeoutCycles);
`endif
        if (shadow_slice == cur_slice) begin
          if (last_port) begin
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!active_sel) begin
          state_d = ST_APPLY;
        end
`ifdef PRIM_RAM_CFG_SEQ_TIMEOUT_EN
        else if (tmo_cnt_q == TmoW'(1)) begin
          // Give up on this port: leave its config alone and move on.
          timeout_d[idx_q] = 1'b1;
          if (last_port) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + IdxW'(1);
            state_d = ST_SEL;
          end
        end else begin
          tmo_cnt_d = tmo_cnt_q - TmoW'(1);
        end
`endif
      end
      ST_APPLY: begin
        ram_cfg_d[int'(idx_q)*SliceW +: SliceW] = shadow_slice;
        settle_d = SetW'(SettleCycles);
        state_d  = ST_SETTLE;
      end
      ST_SETTLE: begin
        settle_d = settle_q - SetW'(1);
        if (settle_q == SetW'(1)) begin
          if (last_port) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + IdxW'(1);
            state_d = ST_SEL;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      shadow_q  <= '0;
      ram_cfg_q <= ResetCfg;
      settle_q  <= '0;
`ifdef PRIM_RAM_CFG_SEQ_TIMEOUT_EN
      tmo_cnt_q <= '0;
      timeout_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      ram_cfg_q <= ram_cfg_d;
      settle_q  <= settle_d;
`ifdef PRIM_RAM_CFG_SEQ_TIMEOUT_EN
      tmo_cnt_q <= tmo_cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  // Hold only the port being worked on, and only while it is being changed.
  always_comb begin
    port_hold_o = '0;
    if (state_q inside {ST_HOLD, ST_APPLY, ST_SETTLE}) begin
      port_hold_o[idx_q] = 1'b1;
    end
  end

  assign ram_cfg_o  = ram_cfg_q;
  assign cfg_busy_o = (state_q != ST_IDLE);
  assign cfg_ack_o  = (state_q == ST_DONE);

`ifdef PRIM_RAM_CFG_SEQ_TIMEOUT_EN
  assign timeout_o = timeout_q;
`else
  assign timeout_o = '0;
`endif

endmodule
